instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs decoded field bundles into 32-bit words behind a
// one-deep output register. Optional immediate range check: INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_addr,
  input  logic [31:0] start_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] out_count,
  output logic        err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q,  out_addr_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic [15:0] out_count_q, out_count_d;
  logic        err_q,       err_d;

  logic [31:0] enc_word;
  logic        fmt_illegal;
  logic        imm_bad;
  logic        reject;
  logic        accept;
  logic        drain;
  logic        take;

  always_comb begin
    enc_word = '0;
    case (in_fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_opcode};
      default: enc_word = '0;
    endcase
  end

  assign fmt_illegal = (in_fmt == 3'd6) || (in_fmt == 3'd7);

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // An immediate fits an N-bit signed field when every bit above N-1 equals the sign bit.
  logic imm_fits12;
  logic imm_fits13;
  logic imm_fits21;

  assign imm_fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign imm_fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign imm_fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    imm_bad = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: imm_bad = !imm_fits12;
      FMT_B:        imm_bad = !imm_fits13 || in_imm[0];
      FMT_J:        imm_bad = !imm_fits21 || in_imm[0];
      FMT_U:        imm_bad = |in_imm[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign reject   = fmt_illegal || imm_bad;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;
  assign take     = accept && !reject;

  // A new word replaces a draining one in the same cycle; addresses are handed
  // out from next_addr_q only to words that are actually emitted.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    out_count_d = out_count_q;
    err_d       = accept && reject;
    if (drain) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + 32'd4;
      if (out_count_q != 16'hFFFF) begin
        out_count_d = out_count_q + 16'd1;
      end
    end
    if (take) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_addr_d  = next_addr_q;
      next_addr_d = next_addr_q + 32'd4;
    end
    if (load_addr) begin
      next_addr_d = start_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      next_addr_q <= '0;
      out_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      out_count_q <= out_count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_count = out_count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a transaction-level scoreboard.
// Honours INSTR_ENC_RANGE_CHECK_EN the same way the design build does.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_addr;
  logic [31:0] start_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [15:0] out_count;
  logic        err;

  instr_encoder dut (
    .clk(clk), .reset(reset), .load_addr(load_addr), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_count(out_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit quiet = 1'b0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } word_t;

  word_t       sb[$];
  logic [31:0] m_next;
  int          m_count;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding from field positions, using only integer arithmetic.
  function automatic logic [31:0] ref_encode(input int fmt, op, rd, rs1, rs2, f3, f7, imm);
    int unsigned u;
    int unsigned w;
    u = imm;
    w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
    case (fmt)
      1: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((u % 4096) << 20);
      2: w = op + ((u % 32) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
             + (((u / 32) % 128) << 25);
      3: w = op + (((u / 2048) % 2) << 7) + (((u / 2) % 16) << 8) + (f3 << 12)
             + (rs1 << 15) + (rs2 << 20) + (((u / 32) % 64) << 25)
             + (((u / 4096) % 2) << 31);
      4: w = op + (rd << 7) + ((u / 4096) << 12);
      5: w = op + (rd << 7) + (((u / 4096) % 256) << 12) + (((u / 2048) % 2) << 20)
             + (((u / 2) % 1024) << 21) + (((u / 1048576) % 2) << 31);
      default: ;
    endcase
    return w;
  endfunction

  function automatic bit ref_rejects(input int fmt, input int imm);
    if (fmt > 5) return 1'b1;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    case (fmt)
      1, 2: return (imm < -2048) || (imm > 2047);
      3:    return (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
      4:    return (imm % 4096) != 0;
      5:    return (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input bit v, input int fmt, op, rd, rs1, rs2, f3, f7, imm,
                       input bit ordy);
    in_valid  = v;
    in_fmt    = 3'(fmt);
    in_opcode = 7'(op);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 32'(imm);
    out_ready = ordy;
  endtask

  // One clock: check presented state, advance the scoreboard, then check registered flags.
  task automatic step();
    bit    exp_ready, acc, drn;
    word_t w;
    #1;
    exp_ready = (sb.size() == 0) || out_ready;
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_eq("out_instr", out_instr, sb[0].instr);
      check_eq("out_addr", out_addr, sb[0].addr);
    end
    acc = in_valid && exp_ready;
    drn = (sb.size() != 0) && out_ready;
    if (drn) begin
      w = sb.pop_front();
      if (!quiet) $display("tb: word @%08h = %08h", w.addr, w.instr);
      if (m_count < 65535) m_count++;
    end
    m_err = 1'b0;
    if (acc) begin
      if (ref_rejects(int'(in_fmt), int'(in_imm))) begin
        m_err = 1'b1;
      end else begin
        sb.push_back('{instr: ref_encode(int'(in_fmt), int'(in_opcode), int'(in_rd),
                                         int'(in_rs1), int'(in_rs2), int'(in_funct3),
                                         int'(in_funct7), int'(in_imm)),
                       addr: m_next});
        m_next += 32'd4;
      end
    end
    if (load_addr) m_next = start_addr;
    @(posedge clk);
    #1;
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("out_count", 32'(out_count), 32'(m_count));
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    in_valid  = 1'b0;
    load_addr = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_out_addr", out_addr, 32'd0);
    check_eq("rst_out_count", 32'(out_count), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    sb.delete();
    m_next  = 32'd0;
    m_count = 0;
    m_err   = 1'b0;
    reset   = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic int rand_imm();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 8191)) - 4096;
      1: return int'($urandom);
      2: return (int'($urandom_range(0, 4095)) - 2048) * 2;
      default: return int'($urandom & 32'hFFFF_F000);
    endcase
  endfunction

  task automatic drive_random();
    int f;
    bit v;
    f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
    v = ($urandom_range(0, 9) < 7);
    drive(v, f, int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), rand_imm(),
          ($urandom_range(0, 9) < 7));
    load_addr = !v && ($urandom_range(0, 7) == 0);
    start_addr = $urandom;
  endtask

  int cnt0;

  initial begin
    reset = 1'b0; load_addr = 1'b0; start_addr = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset(3);

    load_addr = 1'b1; start_addr = 32'h100;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    load_addr = 1'b0;

    drive(1, 0, 'h33, 3, 1, 2, 0, 0, 0, 0); step();
    check_eq("r_instr", out_instr, 32'h002081B3);
    check_eq("r_addr", out_addr, 32'h100);
    drive(1, 1, 'h13, 1, 0, 0, 0, 0, 5, 1); step();
    check_eq("i_instr", out_instr, 32'h00500093);
    check_eq("i_addr", out_addr, 32'h104);
    drive(1, 2, 'h23, 0, 1, 2, 2, 0, 8, 1); step();
    check_eq("s_instr", out_instr, 32'h0020A423);
    drive(1, 3, 'h63, 0, 1, 2, 0, 0, -4, 1); step();
    check_eq("b_instr", out_instr, 32'hFE208EE3);
    drive(1, 5, 'h6F, 1, 0, 0, 0, 0, 2048, 1); step();
    check_eq("j_instr", out_instr, 32'h001000EF);

    cnt0 = m_count;
    drive(1, 0, 'h33, 5, 6, 7, 0, 0, 0, 0);
    repeat (3) begin
      step();
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_hold", out_instr, 32'h001000EF);
    end
    out_ready = 1'b1; step();
    check_eq("bp_count", 32'(out_count), 32'(cnt0 + 1));

    drive(1, 7, 'h13, 1, 0, 0, 0, 0, 0, 1); step();
    check_eq("ill_err", 32'(err), 32'd1);
    check_eq("ill_no_word", 32'(out_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    check_eq("ill_err_once", 32'(err), 32'd0);
    drive(1, 0, 'h33, 1, 1, 1, 0, 0, 0, 1); step();
    check_eq("ill_addr_kept", out_addr, 32'h118);

    drive(1, 1, 'h13, 1, 0, 0, 0, 0, 4096, 1); step();
`ifdef INSTR_ENC_RANGE_CHECK_EN
    check_eq("rng_err", 32'(err), 32'd1);
    check_eq("rng_no_word", 32'(out_valid), 32'd0);
`else
    check_eq("rng_instr", out_instr, 32'h00000093);
    check_eq("rng_err", 32'(err), 32'd0);
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    load_addr = 1'b1; start_addr = 32'hFFFF_FFF8; step();
    load_addr = 1'b0;
    repeat (3) begin
      drive(1, 4, 'h37, 2, 0, 0, 0, 0, 32'h12345000, 1); step();
    end
    check_eq("addr_wrap", out_addr, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      drive_random();
      step();
    end
    load_addr = 1'b0;

    quiet = 1'b1;
    drive(1, 0, 'h33, 1, 2, 3, 0, 0, 0, 1);
    for (int i = 0; i < 70000 && m_count < 65535; i++) step();
    repeat (4) step();
    quiet = 1'b0;
    check_eq("count_sat", 32'(out_count), 32'h0000FFFF);

    drive(1, 0, 'h33, 4, 4, 4, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset(1);
    drive(1, 0, 'h33, 3, 1, 2, 0, 0, 0, 1); step();
    check_eq("post_rst_addr", out_addr, 32'h0);
    check_eq("post_rst_instr", out_instr, 32'h002081B3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
